unlock_seq_tx: RTL and testbench

Transmitter for the 2-bit unlock-code protocol. On a start request it drives the five-symbol code 01, 10, 11, 10, 01 onto the `x1`/`x0` pair, with each symbol lasting exactly one clock and separated by idle (00) gap cycles. It then reports completion. It sits upstream of the unlock detector FSM and drives that FSM's `x1`/`x0` inputs directly on the shared clock.

---
 rtl/unlock_code_pkg.sv | 32 +++
 rtl/unlock_seq_tx.sv | 99 +++++++++
 tb/tb_unlock_seq_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/unlock_code_pkg.sv
// Shared definitions for the 2-bit unlock-code protocol: symbols, the code itself
// and the transmitter state encoding.
package unlock_code_pkg;

    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_A    = 2'b01;
    localparam logic [1:0] SYM_B    = 2'b10;
    localparam logic [1:0] SYM_C    = 2'b11;

    localparam int unsigned CODE_LEN = 5;
    localparam logic [1:0] CODE [CODE_LEN] = '{SYM_A, SYM_B, SYM_C, SYM_B, SYM_A};

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap,
        StDone
    } tx_state_e;

    // Out-of-range indices map to the idle symbol rather than wrapping.
    function automatic logic [1:0] code_sym(input logic [2:0] idx);
        case (idx)
            3'd0:    return CODE[0];
            3'd1:    return CODE[1];
            3'd2:    return CODE[2];
            3'd3:    return CODE[3];
            3'd4:    return CODE[4];
            default: return SYM_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/unlock_seq_tx.sv
// Unlock-code transmitter: sends the five-symbol code with GAP_CYCLES idle
// cycles between symbols, then pulses done.
module unlock_seq_tx
    import unlock_code_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       x1,
    output logic       x0,
    output logic       busy,
    output logic       done,
    output logic [2:0] sym_idx
);

    localparam logic [2:0] LastIdx = 3'(CODE_LEN - 1);

    tx_state_e  state_q, state_d;
    logic [2:0] sym_idx_q, sym_idx_d;
    logic [3:0] gap_q, gap_d;
    logic [1:0] sym_q, sym_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d   = state_q;
        sym_idx_d = sym_idx_q;
        gap_d     = gap_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d   = StSend;
                    sym_idx_d = 3'd0;
                end
            end
            StSend: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (sym_idx_q == LastIdx) begin
                    state_d = StDone;
                end else if (GAP_CYCLES > 0) begin
                    state_d = StGap;
                    gap_d   = 4'(GAP_CYCLES - 1);
                end else begin
                    sym_idx_d = sym_idx_q + 3'd1;
                end
            end
            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (gap_q == 4'd0) begin
                    state_d   = StSend;
                    sym_idx_d = sym_idx_q + 3'd1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered.
        sym_d  = (state_d == StSend) ? code_sym(sym_idx_d) : SYM_IDLE;
        busy_d = (state_d == StSend) || (state_d == StGap);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            sym_idx_q <= 3'd0;
            gap_q     <= 4'd0;
            sym_q     <= SYM_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_idx_q <= sym_idx_d;
            gap_q     <= gap_d;
            sym_q     <= sym_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x1      = sym_q[1];
    assign x0      = sym_q[0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign sym_idx = sym_idx_q;

endmodule

// File: tb/tb_unlock_seq_tx.sv
// Directed bench for unlock_seq_tx with GAP_CYCLES=1 and GAP_CYCLES=0 instances.
module tb_unlock_seq_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start1 = 1'b0, abort1 = 1'b0, start0 = 1'b0, abort0 = 1'b0;
    logic       x1_g1, x0_g1, busy_g1, done_g1;
    logic       x1_g0, x0_g0, busy_g0, done_g0;
    logic [2:0] idx_g1, idx_g0;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected per-cycle values for one GAP_CYCLES=1 code, cycles 1..11.
    logic [1:0] exp_sym1  [1:11] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00,
                                     2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
    logic       exp_busy1 [1:11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic       exp_done1 [1:11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [2:0] exp_idx1  [1:11] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 4};
    // GAP_CYCLES=0, cycles 1..7.
    logic [1:0] exp_sym0  [1:7]  = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
    logic       exp_busy0 [1:7]  = '{1, 1, 1, 1, 1, 0, 0};
    logic       exp_done0 [1:7]  = '{0, 0, 0, 0, 0, 1, 0};
    logic [2:0] exp_idx0  [1:7]  = '{0, 1, 2, 3, 4, 4, 4};

    unlock_seq_tx #(.GAP_CYCLES(1)) dut_g1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .x1(x1_g1), .x0(x0_g1), .busy(busy_g1), .done(done_g1), .sym_idx(idx_g1)
    );

    unlock_seq_tx #(.GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .x1(x1_g0), .x0(x0_g0), .busy(busy_g0), .done(done_g0), .sym_idx(idx_g0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full GAP_CYCLES=1 code; start is sampled at the end of the current cycle.
    task automatic run_g1(input string tag);
        start1 = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            start1 = 1'b0;
            check($sformatf("%s sym c%0d", tag, c), {x1_g1, x0_g1}, exp_sym1[c]);
            check($sformatf("%s busy c%0d", tag, c), busy_g1, exp_busy1[c]);
            check($sformatf("%s done c%0d", tag, c), done_g1, exp_done1[c]);
            check($sformatf("%s idx c%0d", tag, c), idx_g1, exp_idx1[c]);
        end
    endtask

    initial begin
        #12;
        reset = 1'b1;

        // Idle after reset, no start.
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle sym g1", {x1_g1, x0_g1}, 2'b00);
            check("idle busy g1", busy_g1, 1'b0);
            check("idle done g1", done_g1, 1'b0);
            check("idle sym g0", {x1_g0, x0_g0}, 2'b00);
            check("idle busy g0", busy_g0, 1'b0);
        end
        check("reset idx", idx_g1, 3'd0);

        run_g1("gap1");

        // GAP_CYCLES=0: back-to-back symbols.
        start0 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start0 = 1'b0;
            check($sformatf("gap0 sym c%0d", c), {x1_g0, x0_g0}, exp_sym0[c]);
            check($sformatf("gap0 busy c%0d", c), busy_g0, exp_busy0[c]);
            check($sformatf("gap0 done c%0d", c), done_g0, exp_done0[c]);
            check($sformatf("gap0 idx c%0d", c), idx_g0, exp_idx0[c]);
        end

        // Abort during the gap in cycle 4, restart in cycle 6.
        start1 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start1 = 1'b0;
        end
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("abort sym c5", {x1_g1, x0_g1}, 2'b00);
        check("abort busy c5", busy_g1, 1'b0);
        check("abort done c5", done_g1, 1'b0);
        check("abort idx hold", idx_g1, 3'd1);
        tick();
        check("abort done c6", done_g1, 1'b0);
        check("abort sym c6", {x1_g1, x0_g1}, 2'b00);
        run_g1("restart");

        // Start held high: one code every 11 cycles.
        start1 = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            check($sformatf("held sym c%0d", c), {x1_g1, x0_g1}, exp_sym1[((c - 1) % 11) + 1]);
            check($sformatf("held busy c%0d", c), busy_g1, exp_busy1[((c - 1) % 11) + 1]);
            check($sformatf("held done c%0d", c), done_g1, exp_done1[((c - 1) % 11) + 1]);
        end
        start1 = 1'b0;
        tick();
        tick();

        // Start and abort together in IDLE.
        start1 = 1'b1;
        abort1 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("start+abort sym", {x1_g1, x0_g1}, 2'b00);
            check("start+abort busy", busy_g1, 1'b0);
        end
        start1 = 1'b0;
        abort1 = 1'b0;
        tick();

        // Asynchronous reset mid-gap (cycle 4), then a full code.
        start1 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start1 = 1'b0;
        end
        check("pre-rst busy", busy_g1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async rst sym", {x1_g1, x0_g1}, 2'b00);
        check("async rst busy", busy_g1, 1'b0);
        check("async rst done", done_g1, 1'b0);
        check("async rst idx", idx_g1, 3'd0);
        tick();
        reset = 1'b1;
        run_g1("post-rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
